// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//
// Next-state controller for the multicycle CPU. It produces the 5-bit state
// code that the control-signal decoder turns into datapath strobes. During
// ID1 the opcode/func fields are decoded into an instruction class, which is
// latched. Each class then walks a fixed chain of states. Memory states MEM2
// and MEM3 wait on mem_ready. HLT parks the machine in RESET until the next
// reset. Every retired instruction is counted.
//
// Ports:
//   clk          in   system clock, rising-edge active
//   reset        in   asynchronous, active-high reset
//   opcode       in   IR[15:12], sampled in ID1 only
//   func_code    in   IR[5:0], sampled in ID1 only
//   mem_ready    in   data memory access complete (used in MEM2/MEM3)
//   state        out  current state code (0..18)
//   num_inst     out  retired-instruction counter, wraps at 2^CNT_WIDTH
//   inst_done    out  high in the last cycle of each instruction
//   is_halted    out  sticky halt flag, cleared only by reset
//   illegal_inst out  high in ID1 when opcode/func is undefined
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           opcode,
  input  logic [5:0]           func_code,
  input  logic                 mem_ready,
  output logic [4:0]           state,
  output logic [CNT_WIDTH-1:0] num_inst,
  output logic                 inst_done,
  output logic                 is_halted,
  output logic                 illegal_inst
);

  typedef enum logic [4:0] {
    S_RESET = 5'd0,
    S_IF    = 5'd1,
    S_ID1   = 5'd2,
    S_ID2   = 5'd3,
    S_ID3   = 5'd4,
    S_ID4   = 5'd5,
    S_ID5   = 5'd6,
    S_ID6   = 5'd7,
    S_EX1   = 5'd8,
    S_EX2   = 5'd9,
    S_EX3   = 5'd10,
    S_EX4   = 5'd11,
    S_EX5   = 5'd12,
    S_EX6   = 5'd13,
    S_MEM1  = 5'd14,
    S_MEM2  = 5'd15,
    S_MEM3  = 5'd16,
    S_MEM4  = 5'd17,
    S_WB    = 5'd18
  } state_t;

  typedef enum logic [3:0] {
    C_NONE = 4'd0,
    C_RALU = 4'd1,
    C_IMM  = 4'd2,
    C_LWD  = 4'd3,
    C_SWD  = 4'd4,
    C_BR   = 4'd5,
    C_JMP  = 4'd6,
    C_JAL  = 4'd7,
    C_JPR  = 4'd8,
    C_JRL  = 4'd9,
    C_WWD  = 4'd10,
    C_HLT  = 4'd11,
    C_ILL  = 4'd12
  } iclass_t;

  state_t               state_q, state_d;
  iclass_t              class_q;
  iclass_t              dec_class;
  logic [CNT_WIDTH-1:0] num_inst_q;
  logic                 is_halted_q;
  logic                 in_id1;

  assign in_id1 = (state_q == S_ID1);

  // Combinational classification of the IR fields. Only consumed while in ID1;
  // afterwards the latched copy in class_q steers the chain.
  always_comb begin
    dec_class = C_ILL;
    case (opcode)
      4'h0, 4'h1, 4'h2, 4'h3: dec_class = C_BR;
      4'h4, 4'h5, 4'h6:       dec_class = C_IMM;
      4'h7:                   dec_class = C_LWD;
      4'h8:                   dec_class = C_SWD;
      4'h9:                   dec_class = C_JMP;
      4'hA:                   dec_class = C_JAL;
      4'hF: begin
        if (func_code < 6'd8) begin
          dec_class = C_RALU;
        end else begin
          case (func_code)
            6'd25:   dec_class = C_JPR;
            6'd26:   dec_class = C_JRL;
            6'd28:   dec_class = C_WWD;
            6'd29:   dec_class = C_HLT;
            default: dec_class = C_ILL;
          endcase
        end
      end
      default: dec_class = C_ILL;
    endcase
  end

  // Next-state logic. EX states pick their memory state from the latched
  // class, so a stale or changed IR cannot redirect an instruction mid-flight.
  always_comb begin
    state_d = state_q;
    if (is_halted_q) begin
      state_d = S_RESET;
    end else begin
      case (state_q)
        S_RESET: state_d = S_IF;
        S_IF:    state_d = S_ID1;
        S_ID1: begin
          case (dec_class)
            C_RALU:  state_d = S_EX1;
            C_IMM:   state_d = S_EX6;
            C_LWD:   state_d = S_EX2;
            C_SWD:   state_d = S_EX3;
            C_BR:    state_d = S_ID6;
            C_JMP:   state_d = S_ID5;
            C_JAL:   state_d = S_ID2;
            C_JPR:   state_d = S_ID3;
            C_JRL:   state_d = S_ID4;
            C_WWD:   state_d = S_EX5;
            C_HLT:   state_d = S_RESET;
            default: state_d = S_IF;
          endcase
        end
        S_ID2:   state_d = S_ID5;
        S_ID6:   state_d = S_EX4;
        S_EX1, S_EX2, S_EX3, S_EX6: begin
          case (class_q)
            C_RALU:  state_d = S_MEM1;
            C_LWD:   state_d = S_MEM2;
            C_SWD:   state_d = S_MEM3;
            C_IMM:   state_d = S_MEM4;
            default: state_d = S_IF;
          endcase
        end
        S_MEM2:  state_d = mem_ready ? S_WB : S_MEM2;
        S_MEM3:  state_d = mem_ready ? S_IF : S_MEM3;
        // ID3/ID4/ID5/EX4/EX5/MEM1/MEM4/WB finish their chain; unused codes
        // recover to a fresh fetch.
        default: state_d = S_IF;
      endcase
    end
  end

  // Retirement strobe: last state of every chain, plus ID1 for HLT and for
  // undefined encodings (which retire as a NOP).
  always_comb begin
    inst_done = 1'b0;
    case (state_q)
      S_MEM1, S_MEM4, S_WB, S_EX4, S_ID5, S_ID3, S_ID4, S_EX5: inst_done = 1'b1;
      S_MEM3:  inst_done = mem_ready;
      S_ID1:   inst_done = (dec_class == C_HLT) || (dec_class == C_ILL);
      default: inst_done = 1'b0;
    endcase
  end

  assign illegal_inst = in_id1 && (dec_class == C_ILL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RESET;
      class_q     <= C_NONE;
      num_inst_q  <= '0;
      is_halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_id1) begin
        class_q <= dec_class;
      end
      if (in_id1 && (dec_class == C_HLT)) begin
        is_halted_q <= 1'b1;
      end
      if (inst_done) begin
        num_inst_q <= num_inst_q + CNT_WIDTH'(1);
      end
    end
  end

  assign state     = state_q;
  assign num_inst  = num_inst_q;
  assign is_halted = is_halted_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Directed bench for multicycle_sequencer with a 4-bit counter so the wrap
// case is reachable. A table of per-cycle records covers the instruction
// chains; hand-written sequences cover halt, async reset and counter wrap.
// Inputs are driven and outputs sampled around the falling clock edge.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    opcode;
  logic [5:0]    func_code;
  logic          mem_ready;
  logic [4:0]    state;
  logic [CW-1:0] num_inst;
  logic          inst_done;
  logic          is_halted;
  logic          illegal_inst;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] op;
    logic [5:0] fn;
    logic       mr;
    logic [4:0] st;
    logic       done;
    logic       ill;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[$];

  multicycle_sequencer #(.CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .func_code   (func_code),
    .mem_ready   (mem_ready),
    .state       (state),
    .num_inst    (num_inst),
    .inst_done   (inst_done),
    .is_halted   (is_halted),
    .illegal_inst(illegal_inst)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [5:0] fn, input logic mr,
                     input logic [4:0] st, input logic done, input logic ill,
                     input logic [3:0] cnt);
    vec_t v;
    v.op = op; v.fn = fn; v.mr = mr; v.st = st; v.done = done; v.ill = ill; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  // "Junk" IR value (HLT encoding) driven outside ID1 to show it is ignored.
  localparam logic [3:0] JO = 4'hF;
  localparam logic [5:0] JF = 6'd29;

  initial begin
    // ---- vector table: one record per clock cycle -------------------------
    // reset -> ADD
    add(JO, JF, 0, 5'd0,  0, 0, 0);
    add(JO, JF, 0, 5'd1,  0, 0, 0);
    add(4'hF, 6'd0, 0, 5'd2, 0, 0, 0);
    add(JO, JF, 0, 5'd8,  0, 0, 0);
    add(JO, JF, 0, 5'd14, 1, 0, 0);   // MEM1 ignores mem_ready
    // LWD with three stall cycles in MEM2
    add(JO, JF, 0, 5'd1,  0, 0, 1);
    add(4'h7, 6'd0, 0, 5'd2, 0, 0, 1);
    add(JO, JF, 0, 5'd9,  0, 0, 1);
    add(JO, JF, 0, 5'd15, 0, 0, 1);
    add(JO, JF, 0, 5'd15, 0, 0, 1);
    add(JO, JF, 0, 5'd15, 0, 0, 1);
    add(JO, JF, 1, 5'd15, 0, 0, 1);
    add(JO, JF, 0, 5'd18, 1, 0, 1);
    // JAL then JMP
    add(JO, JF, 0, 5'd1,  0, 0, 2);
    add(4'hA, 6'd0, 0, 5'd2, 0, 0, 2);
    add(JO, JF, 0, 5'd3,  0, 0, 2);
    add(JO, JF, 0, 5'd6,  1, 0, 2);
    add(JO, JF, 0, 5'd1,  0, 0, 3);
    add(4'h9, 6'd0, 0, 5'd2, 0, 0, 3);
    add(JO, JF, 0, 5'd6,  1, 0, 3);
    // BEQ then undefined op F func 40
    add(JO, JF, 0, 5'd1,  0, 0, 4);
    add(4'h1, 6'd0, 0, 5'd2, 0, 0, 4);
    add(JO, JF, 0, 5'd7,  0, 0, 4);
    add(JO, JF, 0, 5'd11, 1, 0, 4);
    add(JO, JF, 0, 5'd1,  0, 0, 5);
    add(4'hF, 6'd40, 0, 5'd2, 1, 1, 5);
    add(JO, JF, 0, 5'd1,  0, 0, 6);
    // ADI
    add(4'h4, 6'd0, 0, 5'd2, 0, 0, 6);
    add(JO, JF, 0, 5'd13, 0, 0, 6);
    add(JO, JF, 0, 5'd17, 1, 0, 6);
    add(JO, JF, 0, 5'd1,  0, 0, 7);
    // SWD with one stall in MEM3 (done qualified by mem_ready)
    add(4'h8, 6'd0, 0, 5'd2, 0, 0, 7);
    add(JO, JF, 0, 5'd10, 0, 0, 7);
    add(JO, JF, 0, 5'd16, 0, 0, 7);
    add(JO, JF, 1, 5'd16, 1, 0, 7);
    add(JO, JF, 0, 5'd1,  0, 0, 8);
    // JPR, JRL, WWD
    add(4'hF, 6'd25, 0, 5'd2, 0, 0, 8);
    add(JO, JF, 0, 5'd4,  1, 0, 8);
    add(JO, JF, 0, 5'd1,  0, 0, 9);
    add(4'hF, 6'd26, 0, 5'd2, 0, 0, 9);
    add(JO, JF, 0, 5'd5,  1, 0, 9);
    add(JO, JF, 0, 5'd1,  0, 0, 10);
    add(4'hF, 6'd28, 0, 5'd2, 0, 0, 10);
    add(JO, JF, 0, 5'd12, 1, 0, 10);
    add(JO, JF, 0, 5'd1,  0, 0, 11);

    // ---- reset state -------------------------------------------------------
    reset = 1'b1; opcode = JO; func_code = JF; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_num_inst", num_inst, 0);
    check("rst_inst_done", inst_done, 0);
    check("rst_is_halted", is_halted, 0);
    check("rst_illegal", illegal_inst, 0);
    @(negedge clk);
    reset = 1'b0;

    // ---- table-driven chains ----------------------------------------------
    for (int i = 0; i < tbl.size(); i++) begin
      opcode = tbl[i].op; func_code = tbl[i].fn; mem_ready = tbl[i].mr;
      #1;
      check($sformatf("row%0d_state", i), state, tbl[i].st);
      check($sformatf("row%0d_done", i), inst_done, tbl[i].done);
      check($sformatf("row%0d_illegal", i), illegal_inst, tbl[i].ill);
      check($sformatf("row%0d_num_inst", i), num_inst, tbl[i].cnt);
      check($sformatf("row%0d_halted", i), is_halted, 0);
      @(negedge clk);
    end

    // ---- HLT: parks in RESET, no counting ---------------------------------
    opcode = 4'hF; func_code = 6'd29; mem_ready = 1'b0;
    #1;
    check("hlt_id1_state", state, 2);
    check("hlt_id1_done", inst_done, 1);
    check("hlt_id1_illegal", illegal_inst, 0);
    @(negedge clk);
    opcode = 4'hF; func_code = 6'd0; mem_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      check($sformatf("halt%0d_state", c), state, 0);
      check($sformatf("halt%0d_halted", c), is_halted, 1);
      check($sformatf("halt%0d_num_inst", c), num_inst, 12);
      check($sformatf("halt%0d_done", c), inst_done, 0);
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    check("halt_rst_halted", is_halted, 0);
    check("halt_rst_state", state, 0);
    check("halt_rst_num_inst", num_inst, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("post_rst_state0", state, 0);
    @(negedge clk);
    #1 check("post_rst_state_if", state, 1);

    // ---- async reset mid-SWD in MEM3 --------------------------------------
    opcode = 4'hF; func_code = 6'd0; mem_ready = 1'b1;
    repeat (4) @(negedge clk);        // ADD: ID1, EX1, MEM1, back to IF
    opcode = 4'h8; mem_ready = 1'b0;
    repeat (4) @(negedge clk);        // ID1, EX3, MEM3, MEM3 (stalled)
    #1;
    check("swd_mem3_state", state, 16);
    check("swd_mem3_num_inst", num_inst, 1);
    check("swd_mem3_done", inst_done, 0);
    #2 reset = 1'b1;                  // away from any clock edge
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_num_inst", num_inst, 0);

    // ---- 16 ADDs wrap the 4-bit counter -----------------------------------
    @(negedge clk);
    reset = 1'b0; opcode = 4'hF; func_code = 6'd0; mem_ready = 1'b1;
    repeat (61) @(negedge clk);       // RESET cycle + 15 four-cycle ADDs
    #1;
    check("wrap15_state", state, 1);
    check("wrap15_num_inst", num_inst, 15);
    repeat (4) @(negedge clk);
    #1;
    check("wrap16_state", state, 1);
    check("wrap16_num_inst", num_inst, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
